// File: rtl/alu_ctrl_pkg.sv
// ALU control codes and multiplier FSM state shared by the EX-stage units.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: operand regs, accumulator, shifters, counter.
// ALU_MUL_EARLY_TERM_EN: last step when the remaining multiplier runs out.
module mul_shift_add_dp
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic [XLEN-1:0] sum_o,
  output logic            last_o
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplr_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;
  logic [CW-1:0]   cnt_q;
  logic            cnt_last;

  assign acc_d    = mplr_q[0] ? acc_q + mcand_q : acc_q;
  assign sum_o    = acc_d;
  assign cnt_last = (cnt_q == CW'(XLEN - 1));

`ifdef ALU_MUL_EARLY_TERM_EN
  // multiplier after this step's shift is zero: nothing left to add
  assign last_o = cnt_last | ~|mplr_q[XLEN-1:1];
`else
  assign last_o = cnt_last;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      mcand_q <= data1_i;
      mplr_q  <= data2_i;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (step_i) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential EX-stage multiplier: FSM, pipeline stall and done pulse.
// ALU_MUL_EARLY_TERM_EN enables early termination in the datapath.
module alu_mul_seq
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [3:0]      aluCtrl_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  mul_state_e      state_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic            start;
  logic            step;
  logic            last;
  logic [XLEN-1:0] sum;

  // rst_i gate keeps stall low while reset is held
  assign start = rst_i & (state_q == IDLE) & valid_i
               & (aluCtrl_i == ALU_MUL) & ~flush_i;
  assign step  = (state_q == BUSY) & ~flush_i;

  assign stall_o  = start | (state_q == BUSY);
  assign done_o   = done_q;
  assign result_o = result_q;

  mul_shift_add_dp #(.XLEN(XLEN)) u_dp (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start),
    .step_i  (step),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .sum_o   (sum),
    .last_o  (last)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) state_q <= BUSY;
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (last) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= sum;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits.
REQ-002 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i  input  1  EX stage holds a live instruction.
REQ-005 SHALL have port aluCtrl_i  input  4  ALU control code from the ALU control decoder.
REQ-006 SHALL have port flush_i  input  1  discard EX instruction; abort any multiply.
REQ-007 SHALL have port data1_i  input  XLEN  multiplicand (rs1).
REQ-008 SHALL have port data2_i  input  XLEN  multiplier (rs2).
REQ-009 SHALL have port stall_o  output  1  freeze PC/IF/ID/EX pipeline registers.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; result_o valid.
REQ-011 SHALL have port result_o  output  XLEN  low XLEN bits of data1_i*data2_i.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL start a multiply only in IDLE when valid_i=1, aluCtrl_i=4'b0011 (MUL), flush_i=0; it latches operands, clears accumulator and counter, and enters BUSY next cycle.
REQ-014 SHALL drive stall_o=1 combinationally in the start cycle (IDLE with a qualifying MUL) and in every BUSY cycle; stall_o=0 in DONE and in IDLE otherwise.
REQ-015 SHALL in each BUSY cycle add the shifted multiplicand to the accumulator when the multiplier LSB is 1, shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter; all arithmetic modulo 2^XLEN (overflow discarded, unsigned/signed give identical low bits).
REQ-016 SHALL leave BUSY for DONE after exactly XLEN BUSY cycles (counter value XLEN-1 in the last one), i.e. done_o high on the (XLEN+1)th cycle after the start cycle.
REQ-017 SHALL hold done_o=1 for exactly one cycle in DONE, then return to IDLE unconditionally; valid_i/aluCtrl_i are ignored in DONE (the pipeline advances during DONE).
REQ-018 SHALL hold result_o at the last completed product from DONE until the next start; result_o is 0 before any completion.
REQ-019 SHALL ignore non-MUL aluCtrl_i codes entirely (stall_o=0, no state change).
REQ-020 SHALL on flush_i=1 in BUSY or DONE go to IDLE next cycle with done_o=0 and result_o unchanged; flush_i has priority over completion in the same cycle.
REQ-021 SHALL treat operand value 0 as normal (full-latency result 0 unless REQ-025 applies).

Reset
REQ-022 SHALL on rst_i=0, asynchronously and at any time including mid-multiply: state IDLE, counter 0, accumulator 0, result_o 0, done_o 0, stall_o 0.
REQ-023 SHALL resume normal operation on the first rising clk_i edge after rst_i returns high.

Configuration
REQ-024 SHALL honour macro ALU_MUL_EARLY_TERM_EN.
REQ-025 SHALL, with ALU_MUL_EARLY_TERM_EN defined, go BUSY->DONE on the edge where the remaining multiplier (after this cycle's shift) is zero, giving latency 1 + (index of highest set bit of data2_i, minimum 1 BUSY cycle).
REQ-026 SHALL, without ALU_MUL_EARLY_TERM_EN, use fixed XLEN-cycle latency per REQ-016; results identical either way.

Structure
REQ-027 SHALL take ALU control codes (AND 0000, OR 0001, ADD 0010, MUL 0011, SUB 0110) and the FSM state enum from shared package alu_ctrl_pkg.
REQ-028 SHALL split the shift-add datapath (operand regs, accumulator, shifters, counter) into sub-module mul_shift_add_dp; FSM and stall/done logic stay in alu_mul_seq.

Verification
REQ-029 SHALL cover: MUL 7*6, XLEN=32, no macro -> stall_o high 33 cycles (start+32 BUSY), done_o pulse on cycle 33, result_o=42.
REQ-030 SHALL cover: MUL 0xFFFFFFFF*2 -> result_o=0xFFFFFFFE; MUL 0x80000000*2 -> result_o=0.
REQ-031 SHALL cover: aluCtrl_i=0010 (ADD) and 0110 (SUB) with valid_i=1 -> stall_o=0, done_o never asserts, state stays IDLE.
REQ-032 SHALL cover: flush_i=1 at BUSY cycle 10 of 5*5 -> IDLE next cycle, no done_o, result_o keeps prior value; then fresh MUL 3*4 -> 12.
REQ-033 SHALL cover: rst_i low mid-BUSY (between clock edges) -> stall_o, done_o, result_o 0 immediately; next MUL 9*9 -> 81 with full latency.
REQ-034 SHALL cover: ALU_MUL_EARLY_TERM_EN defined, MUL 1000*3 -> done_o after 2 BUSY cycles, result_o=3000; data2_i=0 -> 1 BUSY cycle, result_o=0.
